// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the bridge FIFO datapath.
// keep_mask gives the byte-keep pattern for a partial word of n bytes.
package bridge_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BYTES      = 4;
  localparam int MAX_BYTES      = 8;

  function automatic logic [MAX_BYTES-1:0] keep_mask(input int n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from the bridge byte FIFO and packs BYTES of them, little-endian,
// into a word on a valid/ready port; a flush emits a partial word with a keep mask.
module fifo_word_packer
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTES      = DEF_BYTES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          empty_i,
  output logic                          rd_en_o,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          flush_i,
  output logic [DATA_WIDTH*BYTES-1:0]   word_o,
  output logic [BYTES-1:0]              keep_o,
  output logic                          word_valid_o,
  input  logic                          word_ready_i
);

  localparam int WW = DATA_WIDTH * BYTES;
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW:0] BYTES_WIDE = (CW + 1)'(BYTES);

  logic [CW-1:0]  cnt_reg, cnt_next, cnt_cap;
  logic           pend_reg;
  logic           flush_pend_reg, flush_pend_next;
  logic [WW-1:0]  asm_reg, asm_next, asm_cap;
  logic [WW-1:0]  word_reg, word_next;
  logic [BYTES-1:0] keep_reg, keep_next, part_keep;
  logic           valid_reg, valid_next;
  logic           slot_free, full_xfer, flush_xfer, flush_drop;

  // Never read past what the assembly register can still absorb, counting the read in flight.
  assign rd_en_o = ~reset & ~empty_i & ~flush_pend_reg &
                   (({1'b0, cnt_reg} + {{CW{1'b0}}, pend_reg}) < BYTES_WIDE);

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign asm_cap[gi*DATA_WIDTH +: DATA_WIDTH] =
      (pend_reg && (cnt_reg == CW'(gi))) ? data_i : asm_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    assign part_keep[gi] = (CW'(gi) < cnt_reg);
  end

  assign cnt_cap    = cnt_reg + CW'(pend_reg);
  assign slot_free  = ~valid_reg | word_ready_i;
  assign full_xfer  = (cnt_cap == CW'(BYTES)) & slot_free;
  assign flush_xfer = flush_pend_reg & ~pend_reg & (cnt_reg != '0) & slot_free & ~full_xfer;
  assign flush_drop = flush_pend_reg & ~pend_reg & (cnt_reg == '0);

  // Assembly is cleared on every transfer, so lanes above cnt are already zero for a flush.
  always_comb begin
    asm_next        = asm_cap;
    cnt_next        = cnt_cap;
    word_next       = word_reg;
    keep_next       = keep_reg;
    valid_next      = valid_reg & ~word_ready_i;
    flush_pend_next = flush_pend_reg | flush_i;
    if (full_xfer) begin
      word_next  = asm_cap;
      keep_next  = '1;
      valid_next = 1'b1;
      asm_next   = '0;
      cnt_next   = '0;
    end else if (flush_xfer) begin
      word_next       = asm_reg;
      keep_next       = part_keep;
      valid_next      = 1'b1;
      asm_next        = '0;
      cnt_next        = '0;
      flush_pend_next = 1'b0;
    end else if (flush_drop) begin
      flush_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      pend_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
      asm_reg        <= '0;
      word_reg       <= '0;
      keep_reg       <= '0;
      valid_reg      <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      pend_reg       <= rd_en_o;
      flush_pend_reg <= flush_pend_next;
      asm_reg        <= asm_next;
      word_reg       <= word_next;
      keep_reg       <= keep_next;
      valid_reg      <= valid_next;
    end
  end

  assign word_o       = word_reg;
  assign keep_o       = keep_reg;
  assign word_valid_o = valid_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: byte FIFO model, directed table,
// hand-written corner sequences and a randomized run against a byte-stream scoreboard.
module tb_fifo_word_packer;
  import bridge_pkg::*;

  logic        clk;
  logic        reset;
  logic        empty_i;
  logic        rd_en_o;
  logic [7:0]  data_i = 8'h00;
  logic        flush_i;
  logic [31:0] word_o;
  logic [3:0]  keep_o;
  logic        word_valid_o;
  logic        word_ready_i;

  fifo_word_packer #(.DATA_WIDTH(8), .BYTES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .empty_i      (empty_i),
    .rd_en_o      (rd_en_o),
    .data_i       (data_i),
    .flush_i      (flush_i),
    .word_o       (word_o),
    .keep_o       (keep_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte FIFO model: data appears on data_i one cycle after a read.
  logic [7:0] fifo_mem [0:1023];
  int pushed_cnt = 0;
  int popped_cnt = 0;
  int stale_reads = 0;
  assign empty_i = (pushed_cnt == popped_cnt);

  always @(posedge clk) begin
    if (rd_en_o) begin
      if (pushed_cnt == popped_cnt) stale_reads <= stale_reads + 1;
      else begin
        data_i     <= fifo_mem[popped_cnt];
        popped_cnt <= popped_cnt + 1;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  int rd_pulses = 0, valid_cycles = 0, hold_errs = 0, empty_rd = 0, got_total = 0;
  logic [31:0] got_word [0:255];
  logic [3:0]  got_keep [0:255];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_word = '0;
  logic [3:0]  prev_keep = '0;

  always @(negedge clk) begin
    if (empty_i && rd_en_o) empty_rd <= empty_rd + 1;
    if (!reset) begin
      if (rd_en_o) rd_pulses <= rd_pulses + 1;
      if (word_valid_o) valid_cycles <= valid_cycles + 1;
      if (word_valid_o && word_ready_i) begin
        got_word[got_total] <= word_o;
        got_keep[got_total] <= keep_o;
        got_total <= got_total + 1;
      end
      if (hold_prev && (!word_valid_o || word_o !== prev_word || keep_o !== prev_keep))
        hold_errs <= hold_errs + 1;
      hold_prev <= word_valid_o & ~word_ready_i;
      prev_word <= word_o;
      prev_keep <= keep_o;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[pushed_cnt] = b;
    pushed_cnt++;
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int i = 0; i < budget && got_total < target; i++) tick();
  endtask

  typedef struct packed {
    logic [31:0] bytes_le;
    int          n;
    logic        flush;
    int          exp_words;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base_g, base_rd, base_v;
    logic [7:0] km;
    logic [7:0] b;
    logic [7:0] rb [0:199];
    int idx;
    vec_t v;

    vecs[0] = '{32'h44332211, 4, 1'b0, 1, 32'h44332211};
    vecs[1] = '{32'h00CCBBAA, 3, 1'b1, 1, 32'h00CCBBAA};
    vecs[2] = '{32'h0000005A, 1, 1'b1, 1, 32'h0000005A};
    vecs[3] = '{32'h00000000, 0, 1'b1, 0, 32'h00000000};
    vecs[4] = '{32'hDEADBEEF, 4, 1'b0, 1, 32'hDEADBEEF};
    vecs[5] = '{32'h00003412, 2, 1'b1, 1, 32'h00003412};
    vecs[6] = '{32'h9A8B7C6D, 4, 1'b1, 1, 32'h9A8B7C6D};

    // Reset with data already waiting: no reads, outputs zero.
    reset = 1'b1; flush_i = 1'b0; word_ready_i = 1'b1;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    repeat (3) begin
      tick();
      check("reset_rd_en", 64'(rd_en_o), 64'(0));
    end
    check("reset_valid", 64'(word_valid_o), 64'(0));
    check("reset_word", 64'(word_o), 64'(0));
    check("reset_keep", 64'(keep_o), 64'(0));

    // Word latency: first read at E0, valid after E0+4.
    reset = 1'b0;
    repeat (4) tick();
    check("latency_early_valid", 64'(word_valid_o), 64'(0));
    tick();
    check("latency_valid", 64'(word_valid_o), 64'(1));
    check("latency_word", 64'(word_o), 64'(32'h13121110));
    check("latency_keep", 64'(keep_o), 64'(4'hF));
    tick();
    check("valid_one_cycle", 64'(word_valid_o), 64'(0));

    // Empty guard.
    repeat (20) begin
      tick();
      check("empty_rd_en", 64'(rd_en_o), 64'(0));
      check("empty_valid", 64'(word_valid_o), 64'(0));
    end

    // Directed table: full words, partial flushes, flush on empty.
    for (int vi = 0; vi < 7; vi++) begin
      v = vecs[vi];
      base_g = got_total; base_rd = rd_pulses; base_v = valid_cycles;
      for (int k = 0; k < v.n; k++) push(v.bytes_le[8*k +: 8]);
      repeat (v.n + 3) tick();
      if (v.flush) begin
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_words(base_g + v.exp_words, 3);
        check("flush_latency_words", 64'(got_total - base_g), 64'(v.exp_words));
      end else begin
        wait_words(base_g + v.exp_words, 10);
      end
      repeat (8) tick();
      check("vec_words", 64'(got_total - base_g), 64'(v.exp_words));
      check("vec_rd_pulses", 64'(rd_pulses - base_rd), 64'(v.n));
      check("vec_valid_cycles", 64'(valid_cycles - base_v), 64'(v.exp_words));
      if (v.exp_words > 0) begin
        km = keep_mask(v.n);
        check("vec_word", 64'(got_word[base_g]), 64'(v.exp_word));
        check("vec_keep", 64'(got_keep[base_g]), 64'(km[3:0]));
      end
    end

    // Peak throughput: one word every BYTES+1 cycles.
    base_g = got_total;
    for (int k = 0; k < 8; k++) push(8'(8'h21 + k));
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("thru_valid", 64'(word_valid_o), 64'((t == 5) || (t == 10)));
    end
    check("thru_count", 64'(got_total - base_g), 64'(2));
    check("thru_word0", 64'(got_word[base_g]), 64'(32'h24232221));
    check("thru_word1", 64'(got_word[base_g + 1]), 64'(32'h28272625));

    // Backpressure: first word held, reads stop with a full assembly behind it.
    base_g = got_total; base_rd = rd_pulses;
    word_ready_i = 1'b0;
    for (int k = 1; k <= 8; k++) push(8'(k));
    repeat (20) tick();
    check("bp_valid", 64'(word_valid_o), 64'(1));
    check("bp_word", 64'(word_o), 64'(32'h04030201));
    check("bp_rd_pulses", 64'(rd_pulses - base_rd), 64'(8));
    repeat (10) tick();
    check("bp_rd_stopped", 64'(rd_pulses - base_rd), 64'(8));
    check("bp_word_held", 64'(word_o), 64'(32'h04030201));
    word_ready_i = 1'b1;
    wait_words(base_g + 2, 20);
    repeat (4) tick();
    check("bp_count", 64'(got_total - base_g), 64'(2));
    check("bp_first", 64'(got_word[base_g]), 64'(32'h04030201));
    check("bp_second", 64'(got_word[base_g + 1]), 64'(32'h08070605));

    // Reset mid-word: partial bytes discarded, next word is clean.
    push(8'h77); push(8'h88);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(word_valid_o), 64'(0));
    check("midrst_word", 64'(word_o), 64'(0));
    check("midrst_keep", 64'(keep_o), 64'(0));
    check("midrst_rd_en", 64'(rd_en_o), 64'(0));
    reset = 1'b0;
    base_g = got_total;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_words(base_g + 1, 12);
    repeat (6) tick();
    check("midrst_count", 64'(got_total - base_g), 64'(1));
    check("midrst_new_word", 64'(got_word[base_g]), 64'(32'hD4C3B2A1));
    check("midrst_new_keep", 64'(got_keep[base_g]), 64'(4'hF));

    // Randomized: random arrival and random backpressure; words are consecutive 4-byte groups.
    base_g = got_total;
    idx = 0;
    for (int c = 0; c < 4000 && (idx < 200 || got_total - base_g < 50); c++) begin
      if (idx < 200 && $urandom_range(0, 2) != 0) begin
        b = 8'($urandom_range(0, 255));
        rb[idx] = b;
        push(b);
        idx++;
      end
      word_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    word_ready_i = 1'b1;
    repeat (6) tick();
    check("rand_count", 64'(got_total - base_g), 64'(50));
    km = keep_mask(4);
    for (int i = 0; i < 50; i++) begin
      check("rand_word", 64'(got_word[base_g + i]),
            64'({rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]}));
      check("rand_keep", 64'(got_keep[base_g + i]), 64'(km[3:0]));
    end

    check("hold_stable", 64'(hold_errs), 64'(0));
    check("rd_en_while_empty", 64'(empty_rd), 64'(0));
    check("stale_reads", 64'(stale_reads), 64'(0));
    check("fifo_drained", 64'(popped_cnt), 64'(pushed_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
